lumi_frame_serializer: RTL and testbench

//  Parametrised next-generation luminosity source for the module emulator. Once per bunch

---
 rtl/lumi_frame_serializer_pkg.sv | 24 ++
 rtl/enc_6b8b.sv | 22 ++
 rtl/lumi_sync_ctrl.sv | 56 +++++
 rtl/lumi_frame_serializer.sv | 136 +++++++++++++
 tb/tb_lumi_frame_serializer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lumi_frame_serializer_pkg.sv
// Shared definitions for the luminosity frame serializer: modes, FSM states, sync bytes.
package lumi_frame_serializer_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_NORMAL    = 2'd1,
    MODE_COUNTER   = 2'd2,
    MODE_SYNC_ONLY = 2'd3
  } mode_e;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [7:0] SYNC_B0 = 8'h47;
  localparam logic [7:0] SYNC_B1 = 8'hE8;

  // Byte j of a sync frame: 47 on even positions, E8 on odd ones.
  function automatic logic [7:0] sync_byte(input int unsigned j);
    return j[0] ? SYNC_B1 : SYNC_B0;
  endfunction

endpackage

// File: rtl/enc_6b8b.sv
// 6b8b line encoder: pads the 6-bit word with a 2-bit prefix that pulls the byte towards
// four ones; prefix 01 is reserved for control characters.
module enc_6b8b (
  input  logic       k_is_char,
  input  logic [5:0] din,
  output logic [7:0] dout
);

  logic [2:0] ones;
  logic [1:0] pad;

  always_comb begin
    ones = '0;
    for (int i = 0; i < 6; i++) ones = ones + 3'(din[i]);
    if (k_is_char)          pad = 2'b01;
    else if (ones < 3'd3)   pad = 2'b11;
    else if (ones > 3'd3)   pad = 2'b00;
    else                    pad = 2'b10;
    dout = {pad, din};
  end

endmodule

// File: rtl/lumi_sync_ctrl.sv
// Frame-type decision for the serializer: pending BCR, periodic sync and the sync frame counter.
module lumi_sync_ctrl
  import lumi_frame_serializer_pkg::*;
#(
  parameter int unsigned SYNC_PERIOD = 0,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic              clk80,
  input  logic              rst_n,
  input  logic              bcr,
  input  logic              load,
  input  mode_e             mode,
  output logic              is_sync,
  output logic [FCNT_W-1:0] sync_cnt
);

  localparam int unsigned PER_W = (SYNC_PERIOD > 0) ? $clog2(SYNC_PERIOD + 1) : 1;

  logic              bcr_pend_q, bcr_pend_d;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic [FCNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic              per_due;

  always_comb begin
    per_due    = (SYNC_PERIOD != 0) && (per_cnt_q == PER_W'(SYNC_PERIOD));
    // A bcr coinciding with the load makes this very frame sync without leaving a pending flag.
    is_sync    = (mode == MODE_SYNC_ONLY) || bcr_pend_q || bcr || per_due;
    bcr_pend_d = bcr_pend_q | bcr;
    per_cnt_d  = per_cnt_q;
    sync_cnt_d = sync_cnt_q;
    if (load) begin
      bcr_pend_d = 1'b0;
      if (is_sync) begin
        per_cnt_d  = '0;
        sync_cnt_d = sync_cnt_q + FCNT_W'(1);
      end else if (SYNC_PERIOD != 0) begin
        per_cnt_d  = per_cnt_q + PER_W'(1);
      end
    end
  end

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      bcr_pend_q <= 1'b0;
      per_cnt_q  <= '0;
      sync_cnt_q <= '0;
    end else begin
      bcr_pend_q <= bcr_pend_d;
      per_cnt_q  <= per_cnt_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign sync_cnt = sync_cnt_q;

endmodule

// File: rtl/lumi_frame_serializer.sv
// Per-BX luminosity frame source: samples NUM_CH lumi words on bx_tick, 6b8b-encodes them and
// streams one byte per clk80, highest channel first, with sync-frame substitution and alignment check.
module lumi_frame_serializer
  import lumi_frame_serializer_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned SYNC_PERIOD = 0,
  parameter int unsigned FCNT_W      = 16
) (
  input  logic                clk80,
  input  logic                rst_n,
  input  logic                bx_tick,
  input  logic                bcr,
  input  logic [1:0]          mode,
  input  logic [6*NUM_CH-1:0] lumi_in,
  output logic [7:0]          dout,
  output logic                frame_start,
  output logic                align_err,
  output logic [FCNT_W-1:0]   sync_cnt
);

  localparam int unsigned       SLOT_W    = $clog2(NUM_CH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  state_e                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  logic [7:0]              dout_q, dout_d;
  logic                    frame_start_q, frame_start_d;
  logic                    align_err_q, align_err_d;
  logic [NUM_CH-2:0][7:0]  shift_q, shift_d;

  mode_e                   mode_sel;
  logic                    is_sync;
  logic [5:0]              ch_val     [NUM_CH];
  logic [7:0]              ch_enc     [NUM_CH];
  logic [7:0]              frame_byte [NUM_CH];

  assign mode_sel = mode_e'(mode);

  lumi_sync_ctrl #(
    .SYNC_PERIOD (SYNC_PERIOD),
    .FCNT_W      (FCNT_W)
  ) u_sync_ctrl (
    .clk80    (clk80),
    .rst_n    (rst_n),
    .bcr      (bcr),
    .load     (bx_tick),
    .mode     (mode_sel),
    .is_sync  (is_sync),
    .sync_cnt (sync_cnt)
  );

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      unique case (mode_sel)
        MODE_NORMAL:  ch_val[k] = lumi_in[6*k +: 6];
        MODE_COUNTER: ch_val[k] = fcnt_q[5:0] + 6'(k);
        default:      ch_val[k] = 6'h00;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_enc
    enc_6b8b u_enc (
      .k_is_char (1'b0),
      .din       (ch_val[k]),
      .dout      (ch_enc[k])
    );
  end

  always_comb begin
    for (int j = 0; j < NUM_CH; j++)
      frame_byte[j] = is_sync ? sync_byte(j) : ch_enc[NUM_CH-1-j];
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d       = state_q;
    slot_d        = slot_q;
    fcnt_d        = fcnt_q;
    dout_d        = dout_q;
    frame_start_d = 1'b0;
    align_err_d   = align_err_q;
    shift_d       = shift_q >> 8;
    if (bx_tick) begin
      // Any tick loads a frame; one arriving before the last slot aborts the current frame.
      if (state_q == ST_RUN && slot_q != LAST_SLOT) align_err_d = 1'b1;
      state_d       = ST_RUN;
      slot_d        = '0;
      fcnt_d        = fcnt_q + FCNT_W'(1);
      frame_start_d = 1'b1;
      dout_d        = frame_byte[0];
      for (int j = 1; j < NUM_CH; j++) shift_d[j-1] = frame_byte[j];
    end else if (state_q == ST_RUN) begin
      if (slot_q == LAST_SLOT) begin
        align_err_d = 1'b1;
        state_d     = ST_ALIGN;
        slot_d      = '0;
        dout_d      = SYNC_B0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
        dout_d = shift_q[0];
      end
    end else begin
      dout_d = (dout_q == SYNC_B0) ? SYNC_B1 : SYNC_B0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ALIGN;
      slot_q        <= '0;
      fcnt_q        <= '0;
      dout_q        <= SYNC_B0;
      frame_start_q <= 1'b0;
      align_err_q   <= 1'b0;
      // NOTE: the byte shift register is small, so it is reset like ordinary state.
      shift_q       <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      fcnt_q        <= fcnt_d;
      dout_q        <= dout_d;
      frame_start_q <= frame_start_d;
      align_err_q   <= align_err_d;
      shift_q       <= shift_d;
    end
  end

  assign dout        = dout_q;
  assign frame_start = frame_start_q;
  assign align_err   = align_err_q;

endmodule

// File: tb/tb_lumi_frame_serializer.sv
// Randomized bench for lumi_frame_serializer: a 2-channel and a 4-channel/period-4 instance run
// side by side against a frame-level reference model.
module tb_lumi_frame_serializer;

  logic        clk80 = 1'b0;
  logic        rst_n;
  logic        bcr;
  logic [1:0]  mode;
  logic [23:0] lumi;
  logic        tick        [2];
  logic [7:0]  dout_o      [2];
  logic        fs_o        [2];
  logic        err_o       [2];
  logic [15:0] sync_cnt_o  [2];

  always #5 clk80 = ~clk80;

  lumi_frame_serializer #(.NUM_CH(2), .SYNC_PERIOD(0), .FCNT_W(16)) u_dut2 (
    .clk80 (clk80), .rst_n (rst_n), .bx_tick (tick[0]), .bcr (bcr), .mode (mode),
    .lumi_in (lumi[11:0]), .dout (dout_o[0]), .frame_start (fs_o[0]),
    .align_err (err_o[0]), .sync_cnt (sync_cnt_o[0])
  );

  lumi_frame_serializer #(.NUM_CH(4), .SYNC_PERIOD(4), .FCNT_W(16)) u_dut4 (
    .clk80 (clk80), .rst_n (rst_n), .bx_tick (tick[1]), .bcr (bcr), .mode (mode),
    .lumi_in (lumi), .dout (dout_o[1]), .frame_start (fs_o[1]),
    .align_err (err_o[1]), .sync_cnt (sync_cnt_o[1])
  );

  int n_checks = 0;
  int n_errors = 0;
  int ph [2];

  // Reference model state, one slot per instance.
  bit          m_run   [2];
  logic [7:0]  m_bytes [2][8];
  int          m_idx   [2];
  int          m_rem   [2];
  logic [15:0] m_fcnt  [2];
  logic [15:0] m_sync  [2];
  bit          m_pend  [2];
  int          m_per   [2];
  bit          m_err   [2];
  logic [7:0]  m_dout  [2];
  bit          m_fs    [2];

  function automatic int nch_of(input int i);
    return (i == 0) ? 2 : 4;
  endfunction

  function automatic int period_of(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic logic [7:0] enc(input logic [5:0] d);
    int n;
    n = $countones(d);
    if (n < 3) return {2'b11, d};
    if (n > 3) return {2'b00, d};
    return {2'b10, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i]  = 1'b0;
      m_idx[i]  = 0;
      m_rem[i]  = 0;
      m_fcnt[i] = '0;
      m_sync[i] = '0;
      m_pend[i] = 1'b0;
      m_per[i]  = 0;
      m_err[i]  = 1'b0;
      m_dout[i] = 8'h47;
      m_fs[i]   = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit tk, input bit b, input logic [1:0] md,
                            input logic [23:0] lu);
    int  n;
    bit  sync;
    logic [5:0] ch;
    n = nch_of(i);
    if (tk) begin
      if (m_run[i] && m_rem[i] != 0) m_err[i] = 1'b1;
      sync = (md == 2'd3) || m_pend[i] || b ||
             (period_of(i) != 0 && m_per[i] == period_of(i));
      for (int j = 0; j < n; j++) begin
        int k;
        k = n - 1 - j;
        case (md)
          2'd1:    ch = lu[6*k +: 6];
          2'd2:    ch = 6'((int'(m_fcnt[i]) + k) % 64);
          default: ch = 6'h00;
        endcase
        m_bytes[i][j] = sync ? ((j % 2 == 0) ? 8'h47 : 8'hE8) : enc(ch);
      end
      m_dout[i] = m_bytes[i][0];
      m_idx[i]  = 1;
      m_rem[i]  = n - 1;
      m_fs[i]   = 1'b1;
      m_fcnt[i] = m_fcnt[i] + 16'd1;
      m_pend[i] = 1'b0;
      if (sync) begin
        m_sync[i] = m_sync[i] + 16'd1;
        m_per[i]  = 0;
      end else begin
        m_per[i]  = m_per[i] + 1;
      end
      m_run[i] = 1'b1;
    end else begin
      m_fs[i] = 1'b0;
      if (b) m_pend[i] = 1'b1;
      if (m_run[i]) begin
        if (m_rem[i] != 0) begin
          m_dout[i] = m_bytes[i][m_idx[i]];
          m_idx[i]  = m_idx[i] + 1;
          m_rem[i]  = m_rem[i] - 1;
        end else begin
          m_err[i]  = 1'b1;
          m_run[i]  = 1'b0;
          m_dout[i] = 8'h47;
        end
      end else begin
        m_dout[i] = (m_dout[i] == 8'h47) ? 8'hE8 : 8'h47;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      string p;
      p = (i == 0) ? "n2" : "n4";
      check({p, ".dout"},        32'(dout_o[i]),     32'(m_dout[i]));
      check({p, ".frame_start"}, 32'(fs_o[i]),       32'(m_fs[i]));
      check({p, ".align_err"},   32'(err_o[i]),      32'(m_err[i]));
      check({p, ".sync_cnt"},    32'(sync_cnt_o[i]), 32'(m_sync[i]));
    end
  endtask

  // One clk80 cycle: drive at the falling edge, step the model at the rising edge, compare 1 ns later.
  task automatic cycle(input bit tick_en, input bit pert, input bit b, input logic [1:0] md,
                       input logic [23:0] lu);
    bit t;
    int r;
    @(negedge clk80);
    bcr  = b;
    mode = md;
    lumi = lu;
    for (int i = 0; i < 2; i++) begin
      t = tick_en && (ph[i] == 0);
      if (tick_en && pert) begin
        r = $urandom_range(0, 24);
        if (r == 0 && t) t = 1'b0;
        else if (r == 1 && !t) begin
          t     = 1'b1;
          ph[i] = 0;
        end
      end
      tick[i] = t;
      if (tick_en) ph[i] = (ph[i] + 1) % nch_of(i);
    end
    @(posedge clk80);
    #1;
    for (int i = 0; i < 2; i++) model_step(i, tick[i], b, md, lu);
    check_all();
  endtask

  initial begin
    rst_n   = 1'b0;
    bcr     = 1'b0;
    mode    = 2'd1;
    lumi    = '0;
    tick[0] = 1'b0;
    tick[1] = 1'b0;
    ph[0]   = 0;
    ph[1]   = 0;
    model_reset();
    repeat (2) @(posedge clk80);
    #1;
    check_all();
    rst_n = 1'b1;

    // Idle alignment pattern, then fixed NORMAL data (2-ch: A95 -> 2A,15).
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 2'd1, 24'h0);
    repeat (40) cycle(1'b1, 1'b0, 1'b0, 2'd1, 24'h5C3A95);

    // bcr mid-frame, then bcr coincident with the 2-channel tick.
    for (int c = 0; c < 24; c++) cycle(1'b1, 1'b0, c == 5, 2'd1, 24'h5C3A95);
    for (int c = 0; c < 24; c++) cycle(1'b1, 1'b0, (c == 9) && (ph[0] == 0), 2'd1, 24'h5C3A95);

    // Counter mode across several mod-64 wraps, then SYNC_ONLY.
    repeat (300) cycle(1'b1, 1'b0, 1'b0, 2'd2, 24'h0);
    repeat (24) cycle(1'b1, 1'b0, 1'b0, 2'd3, 24'($urandom));

    // Random modes changing mid-frame, random data and bcr.
    repeat (200) cycle(1'b1, 1'b0, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                       24'($urandom));

    // Asynchronous reset in the middle of a frame.
    @(negedge clk80);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst.dout",        32'(dout_o[i]),     32'h47);
      check("rst.frame_start", 32'(fs_o[i]),       32'h0);
      check("rst.align_err",   32'(err_o[i]),      32'h0);
      check("rst.sync_cnt",    32'(sync_cnt_o[i]), 32'h0);
    end
    model_reset();
    ph[0] = 0;
    ph[1] = 0;
    repeat (2) @(posedge clk80);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 2'd1, 24'h0);

    // Early and missing ticks with random traffic, then clean recovery.
    repeat (400) cycle(1'b1, 1'b1, $urandom_range(0, 11) == 0, 2'($urandom_range(0, 3)),
                       24'($urandom));
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 2'd1, 24'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
